// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline hazard controller.
//   sb_entry_t  : one shadow-scoreboard entry for an in-flight instruction
//   ST_RUN / ST_WAIT_MEM : controller state encoding (1 bit)
//   REG_ZERO    : architectural zero register, never a real producer
// -----------------------------------------------------------------------------
package pipe_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       regwrite;
    logic       memread;
    logic       memop;      // load or store: may hold the pipe on dmem_ready
  } sb_entry_t;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_WAIT_MEM = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, dest: 5'd0, regwrite: 1'b0,
                                     memread: 1'b0, memop: 1'b0};

endpackage

// File: rtl/hazard_cmp.sv
// -----------------------------------------------------------------------------
// hazard_cmp
// Combinational RAW comparator of one scoreboard entry against the sources of
// the instruction currently in ID.
// Ports:
//   valid, dest, regwrite, memread : fields of the scoreboard entry
//   load_only                      : 1 = only a load producer counts
//   id_rs, id_rt, id_use_rs, id_use_rt : sources of the ID instruction
//   raw_match                      : the ID instruction must wait on this entry
// -----------------------------------------------------------------------------
module hazard_cmp
  import pipe_pkg::*;
(
  input  logic       valid,
  input  logic [4:0] dest,
  input  logic       regwrite,
  input  logic       memread,
  input  logic       load_only,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  output logic       raw_match
);

  // Producer qualification, then source-register compare.
  always_comb begin
    raw_match = 1'b0;
    if (valid && regwrite && (dest != REG_ZERO) && (!load_only || memread)) begin
      raw_match = (id_use_rs && (dest == id_rs)) || (id_use_rt && (dest == id_rt));
    end else begin
      raw_match = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Sequencing controller for the IF/ID, ID/EXE, EXE/MEM and MEM/WB latches.
// Tracks instructions in EXE and MEM and derives latch enables and
// bubble/flush controls for RAW hazards, taken branches and memory waits.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   id_*                : decoded fields of the instruction in ID
//   mem_branch_taken    : branch in EXE/MEM resolved taken
//   dmem_ready          : data memory completes its access this cycle
//   pc_en, *_en         : PC / latch load enables
//   ifid_flush, *_bubble: latch loads a NOP instead of its input
//   state               : 0 = RUN, 1 = WAIT_MEM
//   stall_cnt, flush_cnt: saturating event counters
//   err_timeout         : sticky, set after MEM_TIMEOUT consecutive wait cycles
// The WB stage is not tracked: a WB producer never causes a hazard because the
// register file writes before it reads, so such an entry would have no reader.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter bit FORWARDING  = 1'b0,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_dest,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             mem_branch_taken,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idexe_en,
  output logic             exemem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idexe_bubble,
  output logic             exemem_bubble,
  output logic             memwb_bubble,
  output logic             state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             err_timeout
);

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  sb_entry_t sb_ex_q, sb_ex_d, sb_mem_q, sb_mem_d, id_entry;
  logic [0:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic              err_q, err_d;
  logic              ex_match, mem_match, mem_wait, branch, raw_stall;

  // EX: with forwarding only a load in EX forces a stall.
  hazard_cmp u_cmp_ex (
    .valid(sb_ex_q.valid), .dest(sb_ex_q.dest), .regwrite(sb_ex_q.regwrite),
    .memread(sb_ex_q.memread), .load_only(FORWARDING),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .raw_match(ex_match)
  );

  // MEM: only relevant without forwarding (gated below).
  hazard_cmp u_cmp_mem (
    .valid(sb_mem_q.valid), .dest(sb_mem_q.dest), .regwrite(sb_mem_q.regwrite),
    .memread(sb_mem_q.memread), .load_only(1'b0),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .raw_match(mem_match)
  );

  // Prioritised control outputs and next-state of scoreboard, FSM and counters.
  always_comb begin
    id_entry = '{valid: id_valid, dest: id_dest, regwrite: id_regwrite,
                 memread: id_memread, memop: id_memread | id_memwrite};
    mem_wait  = sb_mem_q.valid && sb_mem_q.memop && !dmem_ready;
    branch    = mem_branch_taken && sb_mem_q.valid;
    raw_stall = ex_match || (!FORWARDING && mem_match);

    pc_en = 1'b1; ifid_en = 1'b1; idexe_en = 1'b1; exemem_en = 1'b1; memwb_en = 1'b1;
    ifid_flush = 1'b0; idexe_bubble = 1'b0; exemem_bubble = 1'b0; memwb_bubble = 1'b0;
    sb_ex_d     = id_entry;
    sb_mem_d    = sb_ex_q;
    state_d     = ST_RUN;
    wait_cnt_d  = '0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    err_d       = err_q;

    if (rst) begin
      pc_en = 1'b0; ifid_en = 1'b0; idexe_en = 1'b0; exemem_en = 1'b0; memwb_en = 1'b0;
      ifid_flush = 1'b1; idexe_bubble = 1'b1; exemem_bubble = 1'b1; memwb_bubble = 1'b1;
      sb_ex_d     = SB_EMPTY;
      sb_mem_d    = SB_EMPTY;
      stall_cnt_d = '0;
      flush_cnt_d = '0;
      err_d       = 1'b0;
    end else if (mem_wait) begin
      // Freeze everything upstream; only WB drains, receiving a NOP.
      pc_en = 1'b0; ifid_en = 1'b0; idexe_en = 1'b0; exemem_en = 1'b0;
      memwb_bubble = 1'b1;
      sb_ex_d    = sb_ex_q;
      sb_mem_d   = sb_mem_q;
      state_d    = ST_WAIT_MEM;
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1'b1);
      if (wait_cnt_d == WAIT_MAX) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else if (branch) begin
      // Wrong-path instructions in IF, ID and EXE are squashed; any RAW stall is moot.
      ifid_flush = 1'b1; idexe_bubble = 1'b1; exemem_bubble = 1'b1;
      sb_ex_d     = SB_EMPTY;
      sb_mem_d    = SB_EMPTY;
      flush_cnt_d = (flush_cnt_q == '1) ? flush_cnt_q : flush_cnt_q + CNT_W'(1'b1);
    end else if (raw_stall) begin
      // Hold PC and IF/ID, inject a bubble into EXE, let older work proceed.
      pc_en = 1'b0; ifid_en = 1'b0;
      idexe_bubble = 1'b1;
      sb_ex_d     = SB_EMPTY;
      stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + CNT_W'(1'b1);
    end else begin
      sb_ex_d = id_entry;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_ex_q     <= SB_EMPTY;
      sb_mem_q    <= SB_EMPTY;
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      sb_ex_q     <= sb_ex_d;
      sb_mem_q    <= sb_mem_d;
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      err_q       <= err_d;
    end
  end

  assign state       = state_q[0];
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign err_timeout = err_q;

endmodule
